// File: rtl/cnn_route_pkg.sv
// Shared types and constants for the PE-array result router.
// Destination indices name the consumers fed from the PE accumulator path.
package cnn_route_pkg;

    typedef enum logic [1:0] {IDLE, ROUTE, DRAIN} route_state_t;

    localparam int DEST_MAIN_BUF = 0;
    localparam int DEST_MAX_POOL = 1;

    // A single destination still needs a one-bit index field.
    function automatic int dest_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/route_out_reg.sv
// Single-entry output register: one data word plus a full flag.
// It can take a new word in the same cycle the held word leaves, so a stream runs at one word per cycle.
module route_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              take_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o,
    output logic              ready_o
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign ready_o = !full_q || take_i;
    assign full_o  = full_q;
    assign data_o  = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load_i) begin
            full_d = 1'b1;
            data_d = load_data_i;
        end else if (take_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/stream_dest_router.sv
// Routes one tile of PE result words to a configured destination with valid/ready flow control.
// Optional build macro ROUTER_STALL_CNT_EN adds a saturating output stall counter (stall_cnt).
module stream_dest_router
    import cnn_route_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_DEST = 2,
    parameter int LEN_W    = 16,
    parameter int DEST_W   = dest_width(NUM_DEST)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [DEST_W-1:0]          cfg_dest,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic [NUM_DEST-1:0]        out_valid,
    input  logic [NUM_DEST-1:0]        out_ready,
    output logic [NUM_DEST*DATA_W-1:0] out_data,
    output logic                       busy,
    output logic                       tile_done,
    output logic                       err_bad_dest
`ifdef ROUTER_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);

    route_state_t      state_q, state_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              tile_done_q, tile_done_d;
    logic              err_q, err_d;

    logic [NUM_DEST-1:0] sel;
    logic                sel_ready;
    logic                reg_full;
    logic                reg_ready;
    logic [DATA_W-1:0]   reg_data;
    logic                load;

    generate
        for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_dest
            assign sel[gi]                         = (dest_q == DEST_W'(gi));
            assign out_valid[gi]                   = sel[gi] && reg_full;
            assign out_data[gi*DATA_W +: DATA_W]   = (sel[gi] && reg_full) ? reg_data : '0;
        end
    endgenerate

    assign sel_ready = |(out_ready & sel);
    assign in_ready  = (state_q == ROUTE) && reg_ready;
    assign load      = in_valid && in_ready;

    route_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .load_data_i (in_data),
        .take_i      (sel_ready),
        .full_o      (reg_full),
        .data_o      (reg_data),
        .ready_o     (reg_ready)
    );

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        remain_d    = remain_q;
        tile_done_d = 1'b0;
        err_d       = 1'b0;
        cfg_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (32'(cfg_dest) >= NUM_DEST) begin
                        err_d = 1'b1;
                    end else if (cfg_len == '0) begin
                        tile_done_d = 1'b1;
                    end else begin
                        dest_d   = cfg_dest;
                        remain_d = cfg_len;
                        state_d  = ROUTE;
                    end
                end
            end
            ROUTE: begin
                if (load) begin
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Done once the last word has left, including the cycle it leaves.
                if (!reg_full || sel_ready) begin
                    tile_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            remain_q    <= '0;
            tile_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            remain_q    <= remain_d;
            tile_done_q <= tile_done_d;
            err_q       <= err_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign tile_done    = tile_done_q;
    assign err_bad_dest = err_q;

`ifdef ROUTER_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && (state_d == ROUTE)) begin
            stall_cnt_d = '0;
        end else if (reg_full && !sel_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
